dmem_lsu_ctrl: RTL and testbench



---
 rtl/dmem_lsu_pkg.sv | 10 +
 rtl/dmem_lsu_align.sv | 24 ++
 rtl/dmem_lsu_ctrl.sv | 110 +++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: funct3 codes, controller states and store lane-merge mask
package dmem_lsu_pkg;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, LD_DATA, RMW_WR} state_t;
  function automatic logic [31:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    return funct3[1:0] == 2'd0 ? 32'h0000_00ff << {offset, 3'b000}
         : funct3[1:0] == 2'd1 ? 32'h0000_ffff << {offset[1], 4'b0000}
         : 32'hffff_ffff;
  endfunction
endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: load byte/half extraction with extension and store lane merge
module dmem_lsu_align import dmem_lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [15:0] sh;
  logic [31:0] mask, rep;
  always_comb begin
    sh = 16'(word >> {offset, 3'b000});
    rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}
          : funct3 == F3_BU ? {24'b0, sh[7:0]}
          : funct3 == F3_H  ? {{16{sh[15]}}, sh}
          : funct3 == F3_HU ? {16'b0, sh}
          : funct3 == F3_W  ? word
          : 32'b0;
    mask = lane_mask(funct3, offset);
    rep = funct3[1:0] == 2'd0 ? {4{wdata[7:0]}} : funct3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
    merged = (word & ~mask) | (rep & mask);
  end
endmodule

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store controller for a word memory with 1-cycle read.
// Define DMEM_LSU_STATS_EN to add load/store/stall/error counters.
module dmem_lsu_ctrl import dmem_lsu_pkg::*; #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_r_enable,
  output logic        mem_w_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_re_data
`ifdef DMEM_LSU_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_errors
`endif
);
  state_t state, state_nx;
  logic [2:0]  l_f3;
  logic [1:0]  l_off;
  logic [29:0] l_idx;
  logic [31:0] l_wdata, ld_data, st_data;
  logic        f3_bad, size_bad, range_bad, err;
  dmem_lsu_align u_align (
    .funct3(l_f3), .offset(l_off), .word(mem_re_data), .wdata(l_wdata),
    .rdata(ld_data), .merged(st_data)
  );
  always_comb begin
    f3_bad = req_we ? req_funct3 > F3_W : req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11;
    size_bad = req_funct3[1:0] == 2'd1 ? req_addr[0] : req_funct3[1:0] == 2'd2 ? |req_addr[1:0] : 1'b0;
    range_bad = {2'b0, req_addr[31:2]} >= 32'(DEPTH_WORDS);
    err = f3_bad | size_bad | range_bad;
    state_nx = state;
    stall = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'b0;
    rsp_err = 1'b0;
    mem_r_enable = 1'b0;
    mem_w_enable = 1'b0;
    mem_address = 32'b0;
    mem_wr_data = 32'b0;
    if (!rst_n) begin
      state_nx = IDLE;
    end else if (state == IDLE) begin
      if (req_valid && err) begin
        rsp_valid = 1'b1;
        rsp_err = 1'b1;
      end else if (req_valid && req_we && req_funct3 == F3_W) begin
        mem_w_enable = 1'b1;
        mem_address = {2'b0, req_addr[31:2]};
        mem_wr_data = req_wdata;
        rsp_valid = 1'b1;
      end else if (req_valid) begin
        mem_r_enable = 1'b1;
        mem_address = {2'b0, req_addr[31:2]};
        stall = 1'b1;
        state_nx = req_we ? RMW_WR : LD_DATA;
      end
    end else if (state == LD_DATA) begin
      rsp_valid = 1'b1;
      rsp_rdata = ld_data;
      state_nx = IDLE;
    end else if (state == RMW_WR) begin
      mem_w_enable = 1'b1;
      mem_address = {2'b0, l_idx};
      mem_wr_data = st_data;
      rsp_valid = 1'b1;
      state_nx = IDLE;
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // the second cycle works only from this copy, so the core may drop its request
  always_ff @(posedge clk)
    if (mem_r_enable) begin
      l_f3 <= req_funct3;
      l_off <= req_addr[1:0];
      l_idx <= req_addr[31:2];
      l_wdata <= req_wdata;
    end
`ifdef DMEM_LSU_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      stat_loads <= 32'b0;
      stat_stores <= 32'b0;
      stat_stall_cycles <= 32'b0;
      stat_errors <= 32'b0;
    end else begin
      stat_loads <= stat_loads + 32'(rsp_valid && !rsp_err && state == LD_DATA);
      stat_stores <= stat_stores + 32'(rsp_valid && !rsp_err && state != LD_DATA);
      stat_stall_cycles <= stat_stall_cycles + 32'(stall);
      stat_errors <= stat_errors + 32'(rsp_err);
    end
`endif
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: directed bench with a behavioural memory/LSU model and per-cycle output compare
module tb_dmem_lsu_ctrl;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic stall, rsp_valid, rsp_err, mem_r_enable, mem_w_enable;
  logic [31:0] rsp_rdata, mem_address, mem_wr_data, mem_re_data;
  logic [31:0] dmem [32];
  logic [31:0] ref_mem [32];
  logic preload;
  logic cmp_en = 1'b0;
  logic e_stall, e_rv, e_err, e_ren, e_wen;
  logic [31:0] e_rd, e_addr, e_wd;
  logic [31:0] rd, wr;
  int checks = 0;
  int errors = 0;

  dmem_lsu_ctrl #(.DEPTH_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_r_enable(mem_r_enable), .mem_w_enable(mem_w_enable),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data), .mem_re_data(mem_re_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (preload) begin
      for (int i = 0; i < 32; i++) dmem[i] <= 32'(i);
    end else begin
      if (mem_w_enable) dmem[mem_address[4:0]] <= mem_wr_data;
      if (mem_r_enable) mem_re_data <= dmem[mem_address[4:0]];
    end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (cmp_en) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("rsp_err", 32'(rsp_err), 32'(e_err));
      check("rsp_rdata", rsp_rdata, e_rd);
      check("mem_r_enable", 32'(mem_r_enable), 32'(e_ren));
      check("mem_w_enable", 32'(mem_w_enable), 32'(e_wen));
      check("mem_address", mem_address, e_addr);
      check("mem_wr_data", mem_wr_data, e_wd);
    end

  function automatic bit m_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned bytes;
    bit legal;
    legal = we ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return !legal || (addr % bytes != 0) || (addr / 4 >= 32);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    longint v;
    int unsigned b;
    b = addr % 4;
    case (f3)
      3'd0: begin v = longint'((w >> (8 * b)) & 32'hff); if (v >= 128) v -= 256; end
      3'd4: v = longint'((w >> (8 * b)) & 32'hff);
      3'd1: begin v = longint'((w >> (8 * b)) & 32'hffff); if (v >= 32768) v -= 65536; end
      3'd5: v = longint'((w >> (8 * b)) & 32'hffff);
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] old, input logic [31:0] wd);
    longint field, m;
    int unsigned b;
    if (f3 == 3'd2) return wd;
    b = addr % 4;
    field = (f3 == 3'd0) ? 255 : 65535;
    m = field << (8 * b);
    return 32'(((longint'(old) & ~m) | ((longint'(wd) & field) << (8 * b))));
  endfunction

  task automatic exp_idle();
    e_stall = 0; e_rv = 0; e_err = 0; e_ren = 0; e_wen = 0;
    e_rd = 0; e_addr = 0; e_wd = 0;
  endtask

  task automatic step(output logic [31:0] r, output logic [31:0] w);
    @(negedge clk);
    r = rsp_rdata;
    w = mem_wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                     input bit drop, input bit rst_mid, output logic [31:0] r, output logic [31:0] w);
    int unsigned idx;
    idx = addr / 4;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    exp_idle();
    if (m_err(we, f3, addr)) begin
      e_rv = 1; e_err = 1;
      step(r, w);
    end else if (we && f3 == 3'd2) begin
      e_wen = 1; e_addr = 32'(idx); e_wd = wd; e_rv = 1;
      step(r, w);
      ref_mem[idx] = wd;
    end else begin
      e_ren = 1; e_addr = 32'(idx); e_stall = 1;
      step(r, w);
      exp_idle();
      if (drop) begin req_valid = 0; req_addr = 32'hdead_beef; req_wdata = 32'h5555_5555; end
      if (rst_mid) rst_n = 0;
      else if (we) begin e_wen = 1; e_addr = 32'(idx); e_wd = m_store(f3, addr, ref_mem[idx], wd); e_rv = 1; end
      else begin e_rv = 1; e_rd = m_load(f3, addr, ref_mem[idx]); end
      step(r, w);
      if (we && !rst_mid) ref_mem[idx] = e_wd;
      rst_n = 1;
    end
    req_valid = 0;
    exp_idle();
  endtask

  initial begin
    rst_n = 0; preload = 1;
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h8; req_wdata = 32'hffff_ffff;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
    exp_idle();
    cmp_en = 1;
    repeat (2) step(rd, wr);
    preload = 0; rst_n = 1; req_valid = 0;
    step(rd, wr);
    check("preload_word3", dmem[3], 32'h3);
    // 1: word store and load
    req(1, 3'd2, 32'h8, 32'h80FF7F01, 0, 0, rd, wr);
    check("sw_wdata", wr, 32'h80FF7F01);
    check("sw_mem", dmem[2], 32'h80FF7F01);
    req(0, 3'd2, 32'h8, 0, 0, 0, rd, wr);
    check("lw_8", rd, 32'h80FF7F01);
    // 2: byte loads with sign/zero extension
    req(0, 3'd0, 32'h9, 0, 0, 0, rd, wr);
    check("lb_9", rd, 32'h0000007F);
    req(0, 3'd0, 32'hB, 0, 0, 0, rd, wr);
    check("lb_b", rd, 32'hFFFFFF80);
    req(0, 3'd4, 32'hB, 0, 0, 0, rd, wr);
    check("lbu_b", rd, 32'h00000080);
    req(0, 3'd0, 32'hA, 0, 0, 0, rd, wr);
    check("lb_a", rd, 32'hFFFFFFFF);
    // 3: halfword read-modify-write and half loads
    req(1, 3'd1, 32'hA, 32'h1234BEEF, 0, 0, rd, wr);
    check("sh_merge", wr, 32'hBEEF7F01);
    check("sh_mem", dmem[2], 32'hBEEF7F01);
    req(0, 3'd5, 32'hA, 0, 0, 0, rd, wr);
    check("lhu_a", rd, 32'h0000BEEF);
    req(0, 3'd1, 32'hA, 0, 0, 0, rd, wr);
    check("lh_a", rd, 32'hFFFFBEEF);
    req(1, 3'd0, 32'h7, 32'h0000_00C3, 0, 0, rd, wr);
    check("sb_merge", wr, 32'hC3000001);
    // 4: error cases
    req(0, 3'd2, 32'h6, 0, 0, 0, rd, wr);
    check("err_lw_misalign", rd, 32'h0);
    req(1, 3'd1, 32'h3, 32'h1111_2222, 0, 0, rd, wr);
    check("err_sh_misalign", rd, 32'h0);
    req(0, 3'd3, 32'h0, 0, 0, 0, rd, wr);
    check("err_illegal_f3", rd, 32'h0);
    req(0, 3'd2, 32'h80, 0, 0, 0, rd, wr);
    check("err_range", rd, 32'h0);
    req(1, 3'd3, 32'h0, 32'h1, 0, 0, rd, wr);
    check("err_store_f3", dmem[0], 32'h0);
    // 5: reset during the write cycle of a byte store
    req(1, 3'd0, 32'h14, 32'hAA, 0, 1, rd, wr);
    check("rst_rmw_keep", dmem[5], 32'h5);
    req(0, 3'd2, 32'h14, 0, 0, 0, rd, wr);
    check("lw_after_rst", rd, 32'h5);
    // 6: request dropped during load data, then back-to-back store
    req(0, 3'd2, 32'h10, 0, 1, 0, rd, wr);
    check("lw_dropped", rd, 32'h4);
    req(1, 3'd2, 32'h0, 32'hCAFEF00D, 0, 0, rd, wr);
    check("sw_b2b", dmem[0], 32'hCAFEF00D);
    step(rd, wr);
    cmp_en = 0;
    for (int i = 0; i < 32; i++) check($sformatf("mem_%0d", i), dmem[i], ref_mem[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
